ps2_scancode_rx: RTL

- PS/2 device-to-host receiver and scancode pre-decoder. Sits between the keyboard pins and the Spectrum matrix mapper.
- Filters and synchronises the PS/2 lines, deserialises 11-bit frames, checks them, folds E0/F0 prefixes into flags, and queues decoded key events in a small FIFO.
- Delivers events through a valid/ready handshake, so the matrix mapper never sees raw frame bits.

---
 rtl/ps2_scancode_rx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_scancode_rx : PS/2 keyboard receiver, prefix folder and event FIFO.    |
// | Optional: PS2_TYPEMATIC_FILTER_EN drops repeated makes of held keys.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 56000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_release,
  output logic       parity_err,
  output logic       overflow
);

  localparam int c_fw = $clog2(FILTER_LEN + 1);
  localparam int c_tw = $clog2(TIMEOUT_CYC + 1);
  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_fw-1:0] c_flt_last = c_fw'(FILTER_LEN - 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYC - 1);
  localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1, r_sync2, r_filt;
  logic [c_fw-1:0] r_fcnt [0:1];
  logic            r_clkf_d;
  logic            w_strobe, w_sdat;

  assign w_raw = {ps2_kbd_data, ps2_kbd_clk};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_clkf_d <= 1'b1;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_clkf_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == c_flt_last) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_strobe = r_clkf_d & ~r_filt[0];
  assign w_sdat   = r_filt[1];

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [c_tw-1:0] r_tmo;
  logic            w_timeout, w_accept, w_reject;

  // A strobe in the same cycle as the timeout wins: the line is still alive.
  assign w_timeout = (r_state != S_IDLE) && (r_tmo == c_tmo_last) && !w_strobe;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE:   if (!w_sdat) w_state_nxt = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (w_sdat && (^{r_shift, r_par})) w_accept = 1'b1;
          else                               w_reject = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_strobe) begin
        case (r_state)
          S_IDLE:   r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {w_sdat, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PARITY: r_par <= w_sdat;
          default:  ;
        endcase
      end
      if (r_state == S_IDLE || w_strobe) r_tmo <= '0;
      else                               r_tmo <= r_tmo + 1'b1;
    end
  end

  logic       r_ext, r_rel, r_push, r_parity_err;
  logic [9:0] r_push_data;
  logic       w_is_ctrl;

  assign w_is_ctrl = (r_shift == 8'hAA) || (r_shift == 8'hFA) || (r_shift == 8'hEE) ||
                     (r_shift == 8'hFE) || (r_shift == 8'h00) || (r_shift == 8'hFF);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_reject;
      r_push       <= 1'b0;
      if (w_accept) begin
        case (r_shift)
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_rel <= 1'b1;
          8'hE1: begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
          end
          default: begin
            if (!(w_is_ctrl && !r_ext && !r_rel)) begin
              r_push      <= 1'b1;
              r_push_data <= {r_ext, r_rel, r_shift};
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  logic [9:0]  r_mem [0:FIFO_DEPTH-1];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic        r_overflow;
  logic        w_full, w_pop, w_push_valid, w_wr;
  logic [9:0]  w_head;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] r_held;
  logic [8:0]   w_key;

  assign w_key        = {r_push_data[9], r_push_data[7:0]};
  assign w_push_valid = r_push && !(!r_push_data[8] && r_held[w_key]);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_held <= '0;
    end else if (w_push_valid) begin
      if (r_push_data[8]) r_held[w_key] <= 1'b0;
      else if (w_wr)      r_held[w_key] <= 1'b1;
    end
  end
`else
  assign w_push_valid = r_push;
`endif

  assign w_full = (r_count == c_depth);
  assign w_pop  = code_valid && code_ready;
  assign w_wr   = w_push_valid && (!w_full || w_pop);

  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push_valid && w_full && !w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked so the outputs read zero whenever the FIFO is empty.
  assign w_head       = code_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign code_valid   = (r_count != '0);
  assign code         = w_head[7:0];
  assign code_release = w_head[8];
  assign code_ext     = w_head[9];
  assign parity_err   = r_parity_err;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire
